// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clock_ctrl
// Description : Programmable CPU bus/control clock generator with free-run,
//               debounced single-step, clean halt/resume and a bus-cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_clock_ctrl #(
    parameter int CNT_WIDTH    = 32,
    parameter int DEFAULT_HALF = 33554432,
    parameter int DEB_CYCLES   = 1000000,
    parameter int CYC_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] half_period,
    input  logic                 load_period,
    input  logic                 mode,
    input  logic                 step_btn,
    input  logic                 hlt,
    input  logic                 resume,
    output logic                 bus_clk,
    output logic                 control_clk,
    output logic                 bus_rise,
    output logic                 bus_fall,
    output logic                 halted,
    output logic [CYC_WIDTH-1:0] cycles
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    localparam logic [2:0] c_RUN_LOW   = 3'd0;
    localparam logic [2:0] c_RUN_HIGH  = 3'd1;
    localparam logic [2:0] c_STEP_WAIT = 3'd2;
    localparam logic [2:0] c_STEP_HIGH = 3'd3;
    localparam logic [2:0] c_STEP_LOW  = 3'd4;
    localparam logic [2:0] c_HALTED    = 3'd5;

    logic [CNT_WIDTH-1:0] r_half;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_state;
    logic                 r_bus_clk;
    logic                 r_ctrl_clk;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_halted;
    logic [CYC_WIDTH-1:0] r_cycles;

    logic                 r_step_s1;
    logic                 r_step_s2;
    logic                 r_deb;
    logic                 r_deb_prev;
    logic [DEB_W-1:0]     r_deb_cnt;

    logic                 r_res_s1;
    logic                 r_res_s2;
    logic                 r_res_prev;

    logic [CNT_WIDTH-1:0] w_h;
    logic                 w_done;
    logic                 w_press;
    logic                 w_resume_edge;
    logic [2:0]           w_n_state;
    logic [CNT_WIDTH-1:0] w_n_cnt;
    logic                 w_n_bus;

    // A zero half-period behaves as one: toggle every clk.
    assign w_h           = (r_half == '0) ? CNT_WIDTH'(1) : r_half;
    assign w_done        = (r_cnt >= (w_h - CNT_WIDTH'(1)));
    assign w_press       = r_deb & ~r_deb_prev;
    assign w_resume_edge = r_res_s2 & ~r_res_prev;

    always_comb begin
        w_n_state = r_state;
        w_n_cnt   = r_cnt + CNT_WIDTH'(1);
        case (r_state)
            c_RUN_LOW: begin
                if (w_done) begin
                    w_n_cnt = '0;
                    if (hlt)       w_n_state = c_HALTED;
                    else if (mode) w_n_state = c_STEP_WAIT;
                    else           w_n_state = c_RUN_HIGH;
                end
            end
            c_RUN_HIGH: begin
                if (w_done) begin
                    w_n_cnt   = '0;
                    w_n_state = c_RUN_LOW;
                end
            end
            c_STEP_WAIT: begin
                w_n_cnt = '0;
                if (hlt)          w_n_state = c_HALTED;
                else if (!mode)   w_n_state = c_RUN_LOW;
                else if (w_press) w_n_state = c_STEP_HIGH;
            end
            c_STEP_HIGH: begin
                if (w_done) begin
                    w_n_cnt   = '0;
                    w_n_state = c_STEP_LOW;
                end
            end
            c_STEP_LOW: begin
                if (w_done) begin
                    w_n_cnt   = '0;
                    w_n_state = c_STEP_WAIT;
                end
            end
            c_HALTED: begin
                w_n_cnt = '0;
                if (w_resume_edge && !hlt)
                    w_n_state = mode ? c_STEP_WAIT : c_RUN_LOW;
            end
            default: begin
                w_n_cnt   = '0;
                w_n_state = c_RUN_LOW;
            end
        endcase
        w_n_bus = (w_n_state == c_RUN_HIGH) || (w_n_state == c_STEP_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half     <= CNT_WIDTH'(DEFAULT_HALF);
            r_cnt      <= '0;
            r_state    <= c_RUN_LOW;
            r_bus_clk  <= 1'b0;
            r_ctrl_clk <= 1'b1;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_halted   <= 1'b0;
            r_cycles   <= '0;
        end else begin
            if (load_period)
                r_half <= half_period;
            r_cnt      <= w_n_cnt;
            r_state    <= w_n_state;
            r_bus_clk  <= w_n_bus;
            r_ctrl_clk <= ~w_n_bus;
            r_rise     <= w_n_bus & ~r_bus_clk;
            r_fall     <= ~w_n_bus & r_bus_clk;
            r_halted   <= (w_n_state == c_HALTED);
            if (w_n_bus && !r_bus_clk)
                r_cycles <= r_cycles + CYC_WIDTH'(1);
        end
    end

    // Debounced level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_s1  <= 1'b0;
            r_step_s2  <= 1'b0;
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_step_s1  <= step_btn;
            r_step_s2  <= r_step_s1;
            r_deb_prev <= r_deb;
            if (r_step_s2 != r_deb) begin
                if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb     <= r_step_s2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_s1   <= 1'b0;
            r_res_s2   <= 1'b0;
            r_res_prev <= 1'b0;
        end else begin
            r_res_s1   <= resume;
            r_res_s2   <= r_res_s1;
            r_res_prev <= r_res_s2;
        end
    end

    assign bus_clk     = r_bus_clk;
    assign control_clk = r_ctrl_clk;
    assign bus_rise    = r_rise;
    assign bus_fall    = r_fall;
    assign halted      = r_halted;
    assign cycles      = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_clock_ctrl
// Description : Directed self-checking bench for cpu_clock_ctrl (H=4, DEB=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] half_period;
    logic        load_period;
    logic        mode;
    logic        step_btn;
    logic        hlt;
    logic        resume;
    logic        bus_clk;
    logic        control_clk;
    logic        bus_rise;
    logic        bus_fall;
    logic        halted;
    logic [15:0] cycles;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_bus;
    logic [15:0] c0;
    logic [15:0] dc;
    int          waited;

    cpu_clock_ctrl #(
        .CNT_WIDTH   (32),
        .DEFAULT_HALF(4),
        .DEB_CYCLES  (3),
        .CYC_WIDTH   (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .half_period(half_period),
        .load_period(load_period),
        .mode       (mode),
        .step_btn   (step_btn),
        .hlt        (hlt),
        .resume     (resume),
        .bus_clk    (bus_clk),
        .control_clk(control_clk),
        .bus_rise   (bus_rise),
        .bus_fall   (bus_fall),
        .halted     (halted),
        .cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("ctrl_inv", control_clk ^ bus_clk, 1);
            check_eq("rise_fall_excl", bus_rise & bus_fall, 0);
            check_eq("halt_no_strobe", halted & (bus_rise | bus_fall), 0);
        end
    end

    initial begin
        rst_n = 1'b0; half_period = '0; load_period = 1'b0; mode = 1'b0;
        step_btn = 1'b0; hlt = 1'b0; resume = 1'b0;

        // Reset state
        tick(2);
        check_eq("rst_bus", bus_clk, 0);
        check_eq("rst_ctrl", control_clk, 1);
        check_eq("rst_rise", bus_rise, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_cycles", cycles, 0);
        rst_n = 1'b1;

        // Free-run at H=4: rises at edges 4, 12, 20
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check_eq("run_bus", bus_clk, (k >= 4 && ((k - 4) % 8) < 4) ? 1 : 0);
            check_eq("run_rise", bus_rise, (k >= 4 && ((k - 4) % 8) == 0) ? 1 : 0);
            check_eq("run_fall", bus_fall, (k >= 8 && ((k - 8) % 8) == 0) ? 1 : 0);
        end
        check_eq("run_cycles", cycles, 3);

        // Halt requested mid high phase: phase completes, then halts at would-be rise
        tick(1);
        hlt = 1'b1;
        tick(1); check_eq("hlt_hi22", bus_clk, 1);
        tick(1); check_eq("hlt_hi23", bus_clk, 1);
        tick(1); check_eq("hlt_fall24", bus_fall, 1);
        check_eq("hlt_bus24", bus_clk, 0);
        tick(3); check_eq("hlt_pre27", halted, 0);
        tick(1); check_eq("hlt_at28", halted, 1);
        check_eq("hlt_bus28", bus_clk, 0);
        check_eq("hlt_rise28", bus_rise, 0);
        resume = 1'b1;
        tick(5); check_eq("resume_ignored", halted, 1);
        resume = 1'b0;
        tick(3);
        hlt = 1'b0; resume = 1'b1;
        tick(2); check_eq("res_r2", halted, 1);
        tick(1); check_eq("res_r3", halted, 0);
        tick(3); check_eq("res_r6", bus_clk, 0);
        tick(1); check_eq("res_r7", bus_rise, 1);
        check_eq("res_cycles", cycles, 4);
        resume = 1'b0;

        // Single-step: settle into STEP_WAIT, then a 1-clk glitch
        mode = 1'b1;
        tick(12); check_eq("sw_bus", bus_clk, 0);
        step_btn = 1'b1; tick(1); step_btn = 1'b0;
        tick(10);
        check_eq("glitch_bus", bus_clk, 0);
        check_eq("glitch_cycles", cycles, 4);

        // Clean 10-clk press: one 4-clk pulse at edges 6..9
        step_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            if (e == 10) step_btn = 1'b0;
            check_eq("step_bus", bus_clk, (e >= 6 && e <= 9) ? 1 : 0);
            check_eq("step_rise", bus_rise, (e == 6) ? 1 : 0);
        end
        check_eq("step_cycles", cycles, 5);

        // Short press, then a second press whose accept lands in STEP_LOW
        step_btn = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick(1);
            if (e == 3)  step_btn = 1'b0;
            if (e == 6)  step_btn = 1'b1;
            if (e == 12) step_btn = 1'b0;
            check_eq("dbl_bus", bus_clk, (e >= 6 && e <= 9) ? 1 : 0);
        end
        check_eq("dbl_cycles", cycles, 6);

        // Period change mid high phase
        half_period = 32'd10; load_period = 1'b1;
        tick(1); load_period = 1'b0; mode = 1'b0;
        tick(10); check_eq("h10_f11", bus_clk, 0);
        tick(1);  check_eq("h10_rise", bus_rise, 1);
        tick(6);
        half_period = 32'd3; load_period = 1'b1;
        tick(1); load_period = 1'b0;
        check_eq("ld_f19", bus_clk, 1);
        tick(1);
        check_eq("ld_fall", bus_fall, 1);
        check_eq("ld_bus", bus_clk, 0);
        for (int f = 21; f <= 26; f++) begin
            tick(1);
            check_eq("h3_bus", bus_clk, (f >= 23 && f <= 25) ? 1 : 0);
            check_eq("h3_rise", bus_rise, (f == 23) ? 1 : 0);
        end

        // Zero half-period: toggle every clk
        half_period = 32'd0; load_period = 1'b1;
        tick(1); load_period = 1'b0;
        tick(1);
        prev_bus = bus_clk;
        c0 = cycles;
        for (int g = 0; g < 10; g++) begin
            tick(1);
            check_eq("h0_toggle", bus_clk ^ prev_bus, 1);
            check_eq("h0_rise", bus_rise, bus_clk);
            prev_bus = bus_clk;
        end
        dc = cycles - c0;
        check_eq("h0_cycles", dc, 5);

        // Reset during STEP_HIGH
        half_period = 32'd4; load_period = 1'b1;
        tick(1); load_period = 1'b0; mode = 1'b1;
        tick(12);
        step_btn = 1'b1;
        waited = 0;
        while (!bus_clk && waited < 50) begin
            tick(1);
            waited++;
        end
        check_eq("rst_step_seen", bus_clk, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_bus", bus_clk, 0);
        check_eq("mrst_ctrl", control_clk, 1);
        check_eq("mrst_cycles", cycles, 0);
        step_btn = 1'b0; mode = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3); check_eq("mrst_e3", bus_clk, 0);
        tick(1); check_eq("mrst_e4", bus_rise, 1);
        check_eq("mrst_cyc1", cycles, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
